frank_ctrl: RTL and testbench



---
 rtl/frank_ctrl_pkg.sv | 38 +++
 rtl/frank_ctrl_if.sv | 29 ++
 rtl/frank_branch_eval.sv | 10 +
 rtl/frank_ctrl.sv | 109 ++++++++++
 tb/tb_frank_ctrl.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/frank_ctrl_pkg.sv
// Shared definitions for the FRANK instruction sequencer: opcodes, FSM states,
// instruction field positions and flag bit indices.
package frank_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEMRD  = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALUI = 4'h1;
  localparam logic [3:0] OP_ALUM = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_STW  = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_BRC  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'h7;

  localparam int MAJ_HI = 15;
  localparam int MAJ_LO = 12;
  localparam int SUB_HI = 11;
  localparam int SUB_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  // Majors 8..F are undefined; the top bit alone identifies them.
  function automatic logic is_illegal(input logic [3:0] major);
    return major[3];
  endfunction

endpackage

// File: rtl/frank_ctrl_if.sv
// Bus bundle between the sequencer and its instruction memory, data memory and ALU.
interface frank_ctrl_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] imem_addr;
  logic [15:0]     imem_data;
  logic [7:0]      dmem_addr;
  logic            dmem_rd;
  logic [7:0]      dmem_rdata;
  logic            dmem_wr;
  logic [7:0]      dmem_wdata;
  logic [3:0]      alu_opcode;
  logic [7:0]      alu_w;
  logic [7:0]      alu_p;
  logic [7:0]      alu_res;
  logic [2:0]      alu_status;

  modport master (
    output imem_addr, dmem_addr, dmem_rd, dmem_wr, dmem_wdata,
           alu_opcode, alu_w, alu_p,
    input  imem_data, dmem_rdata, alu_res, alu_status
  );

  modport slave (
    input  imem_addr, dmem_addr, dmem_rd, dmem_wr, dmem_wdata,
           alu_opcode, alu_w, alu_p,
    output imem_data, dmem_rdata, alu_res, alu_status
  );
endinterface

// File: rtl/frank_branch_eval.sv
// Conditional branch resolution: any selected flag set, optionally inverted by sub[3].
module frank_branch_eval
  import frank_ctrl_pkg::*;
(
  input  logic [3:0] sub_i,
  input  logic [2:0] flags_i,
  output logic       taken_o
);
  assign taken_o = (|(sub_i[2:0] & flags_i)) ^ sub_i[3];
endmodule

// File: rtl/frank_ctrl.sv
// FRANK sequencer/decoder: FETCH/DECODE/[MEMRD]/EXEC loop owning PC, IR, WREG,
// flags and the data-memory strobes.
module frank_ctrl
  import frank_ctrl_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  frank_ctrl_if.master      bus,
  output logic [7:0]        wreg,
  output logic [2:0]        flags,
  output logic              halted,
  output logic              illegal
);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic [7:0]      wreg_q;
  logic [2:0]      flags_q;
  logic            halted_q;
  logic            illegal_q;

  logic [3:0]      major;
  logic [3:0]      sub;
  logic [7:0]      imm;
  logic [PC_W-1:0] target;
  logic            taken;

  assign major = ir_q[MAJ_HI:MAJ_LO];
  assign sub   = ir_q[SUB_HI:SUB_LO];
  assign imm   = ir_q[IMM_HI:IMM_LO];

  // Branch targets are absolute: zero-extend or truncate the 8-bit address.
  generate
    if (PC_W > 8) begin : g_tgt_ext
      assign target = {{(PC_W-8){1'b0}}, imm};
    end else begin : g_tgt_trunc
      assign target = imm[PC_W-1:0];
    end
  endgenerate

  frank_branch_eval u_branch (
    .sub_i   (sub),
    .flags_i (flags_q),
    .taken_o (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      wreg_q    <= '0;
      flags_q   <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      unique case (state_q)
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          ir_q      <= bus.imem_data;
          pc_q      <= pc_q + PC_W'(1);
          illegal_q <= is_illegal(bus.imem_data[MAJ_HI:MAJ_LO]);
          state_q   <= (bus.imem_data[MAJ_HI:MAJ_LO] == OP_ALUM) ? ST_MEMRD : ST_EXEC;
        end
        ST_MEMRD: state_q <= ST_EXEC;
        ST_EXEC: begin
          state_q <= ST_FETCH;
          // A branch write here wins over the increment done in DECODE.
          case (major)
            OP_ALUI, OP_ALUM: begin
              wreg_q  <= bus.alu_res;
              flags_q <= bus.alu_status;
            end
            OP_LDI:  wreg_q <= imm;
            OP_JMP:  pc_q   <= target;
            OP_BRC:  if (taken) pc_q <= target;
            OP_HALT: begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end
            default: ;
          endcase
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign bus.imem_addr  = pc_q;
  assign bus.dmem_addr  = imm;
  assign bus.dmem_rd    = (state_q == ST_MEMRD);
  assign bus.dmem_wr    = (state_q == ST_EXEC) && (major == OP_STW);
  assign bus.dmem_wdata = wreg_q;
  assign bus.alu_opcode = sub;
  assign bus.alu_w      = wreg_q;
  assign bus.alu_p      = ((state_q == ST_EXEC) && (major == OP_ALUM)) ? bus.dmem_rdata : imm;

  assign wreg    = wreg_q;
  assign flags   = flags_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_frank_ctrl.sv
// Directed bench for frank_ctrl with behavioural instruction/data memories and ALU.
module tb_frank_ctrl;

  localparam int PC_W = 8;
  localparam logic [3:0] ADDWP = 4'h1;
  localparam logic [3:0] SUBWP = 4'h2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frank_ctrl_if #(.PC_W(PC_W)) bus ();
  logic [7:0] wreg;
  logic [2:0] flags;
  logic       halted;
  logic       illegal;

  frank_ctrl #(.PC_W(PC_W), .RESET_PC(8'h00)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .wreg    (wreg),
    .flags   (flags),
    .halted  (halted),
    .illegal (illegal)
  );

  logic [15:0] imem [0:255];
  logic [7:0]  dmem [0:255];

  always @(posedge clk) begin
    bus.imem_data <= imem[bus.imem_addr];
    if (bus.dmem_rd) bus.dmem_rdata <= dmem[bus.dmem_addr];
    if (bus.dmem_wr) dmem[bus.dmem_addr] <= bus.dmem_wdata;
  end

  // ALU model: C is carry for add and borrow for subtract.
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = {1'b0, bus.alu_w};
    case (bus.alu_opcode)
      ADDWP:   alu_sum = {1'b0, bus.alu_w} + {1'b0, bus.alu_p};
      SUBWP:   alu_sum = {1'b0, bus.alu_w} - {1'b0, bus.alu_p};
      default: alu_sum = {1'b0, bus.alu_w};
    endcase
    bus.alu_res    = alu_sum[7:0];
    bus.alu_status = {alu_sum[8], alu_sum[7], (alu_sum[7:0] == 8'h00)};
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] brc_exp [0:2];

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 8'h00;
    end
    imem[0]     = 16'h4040;
    dmem[8'h40] = 8'h10;

    // Reset abort of STW
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rst_addr0", bus.imem_addr, 8'h00);
    step(2);
    rst_n = 1'b0;
    #1;
    check("rst_wr_low", bus.dmem_wr, 1'b0);
    step(2);
    check("rst_wr_hold", bus.dmem_wr, 1'b0);
    check("rst_mem_kept", dmem[8'h40], 8'h10);
    $display("STW 4040 aborted by reset");

    imem[8'h00] = 16'h30F0;
    imem[8'h01] = {4'h1, ADDWP, 8'h20};
    imem[8'h02] = {4'h2, SUBWP, 8'h40};
    imem[8'h03] = 16'h6133;
    imem[8'h33] = 16'h6933;
    imem[8'h34] = 16'h6433;
    imem[8'h35] = 16'h50FF;
    imem[8'hFF] = 16'h0000;
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("rel_state", {bus.imem_addr, wreg, flags, bus.dmem_rd, bus.dmem_wr, halted, illegal},
          {8'h00, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
    step(1);
    check("rel_no_strobe", {bus.dmem_rd, bus.dmem_wr}, 2'b00);

    step(2);
    check("ldi_wreg", {bus.imem_addr, wreg, flags}, {8'h01, 8'hF0, 3'b000});
    $display("LDI 30F0 wreg=%0h", wreg);

    step(2);
    check("alui_ops", {bus.alu_opcode, bus.alu_w, bus.alu_p}, {ADDWP, 8'hF0, 8'h20});
    step(1);
    check("alui_res", {bus.imem_addr, wreg, flags}, {8'h02, 8'h10, 3'b100});
    $display("ALUI ADDWP 20 wreg=%0h flags=%b", wreg, flags);

    step(1);
    check("alum_dec_rd", bus.dmem_rd, 1'b0);
    step(1);
    check("alum_rd", {bus.dmem_rd, bus.dmem_addr}, {1'b1, 8'h40});
    step(1);
    check("alum_exec", {bus.dmem_rd, bus.alu_opcode, bus.alu_p}, {1'b0, SUBWP, 8'h10});
    step(1);
    check("alum_res", {bus.imem_addr, wreg, flags, bus.dmem_rd}, {8'h03, 8'h00, 3'b001, 1'b0});
    $display("ALUM SUBWP 40 wreg=%0h flags=%b", wreg, flags);

    brc_exp[0] = 8'h33;
    brc_exp[1] = 8'h34;
    brc_exp[2] = 8'h35;
    for (int i = 0; i < 3; i++) begin
      step(3);
      check("brc_target", bus.imem_addr, brc_exp[i]);
      $display("BRC %0d next fetch %0h", i, bus.imem_addr);
    end
    check("brc_flags_kept", flags, 3'b001);

    step(3);
    check("jmp_target", bus.imem_addr, 8'hFF);
    imem[8'h00] = 16'h8000;
    imem[8'h01] = 16'h7000;
    step(3);
    check("nop_wrap", bus.imem_addr, 8'h00);
    $display("JMP FF then NOP, next fetch %0h", bus.imem_addr);

    step(1);
    check("ill_dec", illegal, 1'b0);
    step(1);
    check("ill_pulse", illegal, 1'b1);
    step(1);
    check("ill_after", {illegal, bus.imem_addr, wreg, flags, halted}, {1'b0, 8'h01, 8'h00, 3'b001, 1'b0});
    $display("ILLEGAL 8000 pulse seen");

    step(3);
    check("halt_set", {halted, bus.imem_addr}, {1'b1, 8'h02});
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("halt_frozen", {halted, bus.imem_addr, bus.dmem_rd, bus.dmem_wr, wreg, flags},
            {1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 3'b001});
    end
    $display("HALT 7000 held for 20 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
